// File: rtl/counter_down_timer.sv
// counter_down_timer: loadable down-counter with valid/ready start and one-cycle done pulse
module counter_down_timer #(
  parameter int                 WIDTH_P   = 4,
  parameter logic [WIDTH_P-1:0] RESET_VAL = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_v_i,
  input  logic [WIDTH_P-1:0] start_val_i,
  output logic               start_ready_o,
  input  logic               down_i,
  input  logic               abort_i,
  output logic [WIDTH_P-1:0] count_o,
  output logic               busy_o,
  output logic               done_o
);
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;
  state_e             state_r, state_n;
  logic [WIDTH_P-1:0] count_r, count_n;
  logic               accept;
  assign accept  = start_v_i & start_ready_o;
  assign count_o = count_r;
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state_r <= IDLE;
      count_r <= RESET_VAL;
    end else begin
      state_r <= state_n;
      count_r <= count_n;
    end
  always_comb begin
    state_n = state_r;
    count_n = count_r;
    if (accept) begin
      count_n = start_val_i;
      state_n = (start_val_i != '0) ? COUNT : DONE;
    end else if (state_r == DONE) begin
      state_n = IDLE;
    end else if (state_r == COUNT && abort_i) begin
      state_n = IDLE;
      count_n = '0;
    end else if (state_r == COUNT && down_i) begin
      count_n = count_r - WIDTH_P'(1);
      state_n = (count_r == WIDTH_P'(1)) ? DONE : COUNT;
    end
  end
  always_comb begin
    start_ready_o = (state_r == IDLE) || (state_r == DONE);
    busy_o        = state_r == COUNT;
    done_o        = state_r == DONE;
  end
endmodule

// File: tb/tb_counter_down_timer.sv
// tb_counter_down_timer: directed vectors for the down-counting timer
module tb_counter_down_timer;
  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_v_i = 1'b0;
  logic [3:0] start_val_i = '0;
  logic       start_ready_o;
  logic       down_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [3:0] count_o;
  logic       busy_o;
  logic       done_o;
  int         n_checks = 0;
  int         n_fail = 0;
  counter_down_timer #(.WIDTH_P(4), .RESET_VAL(4'd5)) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .start_v_i(start_v_i),
    .start_val_i(start_val_i),
    .start_ready_o(start_ready_o),
    .down_i(down_i),
    .abort_i(abort_i),
    .count_o(count_o),
    .busy_o(busy_o),
    .done_o(done_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic expect_out(input string tag, input int cnt, input bit rdy, input bit bsy, input bit dn);
    check({tag, ".count"}, 32'(count_o), 32'(cnt));
    check({tag, ".ready"}, 32'(start_ready_o), 32'(rdy));
    check({tag, ".busy"}, 32'(busy_o), 32'(bsy));
    check({tag, ".done"}, 32'(done_o), 32'(dn));
  endtask
  initial begin
    int seq4 [7] = '{4, 3, 3, 3, 2, 1, 0};
    bit pat4 [6] = '{1, 0, 0, 1, 1, 1};
    step();
    step();
    expect_out("reset", 5, 1, 0, 0);
    reset_i = 1'b0;
    step();
    expect_out("idle_hold", 5, 1, 0, 0);
    start_v_i = 1'b1; start_val_i = 4'd3; down_i = 1'b1;
    step();
    start_v_i = 1'b0;
    expect_out("s3_c3", 3, 0, 1, 0);
    step();
    expect_out("s3_c2", 2, 0, 1, 0);
    step();
    expect_out("s3_c1", 1, 0, 1, 0);
    step();
    expect_out("s3_done", 0, 1, 0, 1);
    step();
    expect_out("s3_idle", 0, 1, 0, 0);
    start_v_i = 1'b1; start_val_i = 4'd4;
    step();
    start_v_i = 1'b0;
    expect_out("s4_c0", seq4[0], 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      down_i = pat4[i];
      step();
      expect_out($sformatf("s4_c%0d", i + 1), seq4[i + 1], i == 5, i != 5, i == 5);
    end
    down_i = 1'b1;
    step();
    expect_out("s4_idle", 0, 1, 0, 0);
    start_v_i = 1'b1; start_val_i = 4'd0;
    step();
    start_v_i = 1'b0;
    expect_out("s0_done", 0, 1, 0, 1);
    step();
    expect_out("s0_idle", 0, 1, 0, 0);
    start_v_i = 1'b1; start_val_i = 4'd1;
    step();
    start_v_i = 1'b0;
    expect_out("b2b_c1", 1, 0, 1, 0);
    step();
    expect_out("b2b_done1", 0, 1, 0, 1);
    start_v_i = 1'b1; start_val_i = 4'd2;
    step();
    expect_out("b2b_c2", 2, 0, 1, 0);
    start_val_i = 4'd7;
    step();
    start_v_i = 1'b0;
    expect_out("b2b_ignore", 1, 0, 1, 0);
    step();
    expect_out("b2b_done2", 0, 1, 0, 1);
    step();
    expect_out("b2b_idle", 0, 1, 0, 0);
    start_v_i = 1'b1; start_val_i = 4'd15;
    step();
    start_v_i = 1'b0;
    for (int i = 0; i < 6; i++) step();
    expect_out("ab_c9", 9, 0, 1, 0);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    expect_out("ab_idle", 0, 1, 0, 0);
    step();
    expect_out("ab_after", 0, 1, 0, 0);
    start_v_i = 1'b1; start_val_i = 4'd15;
    step();
    start_v_i = 1'b0;
    for (int i = 0; i < 6; i++) step();
    expect_out("rst_c9", 9, 0, 1, 0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    expect_out("rst_idle", 5, 1, 0, 0);
    step();
    expect_out("rst_after", 5, 1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/counter_down_timer.md
# counter_down_timer

Loadable down-counting timer for the ice40 DDR controller: accepts a start value through a valid/ready handshake, decrements while enabled, and emits a one-cycle done pulse on reaching zero. It is the counterpart of the existing up-counter. The command sequencer uses it to enforce DDR timing constraints (tRCD, tRP, tRFC, refresh interval), re-arming it back-to-back between commands.

## Interface
- WIDTH_P, default 4: counter width in bits. Maximum programmable delay is 2^WIDTH_P-1.
- RESET_VAL, default 0: value `count_o` takes in reset.
- clk_i  input  1  single clock; all logic on posedge.
- reset_i  input  1  synchronous, active-high reset.
- start_v_i  input  1  start request valid.
- start_val_i  input  WIDTH_P  initial count, sampled when the start handshake fires.
- start_ready_o  output  1  timer can accept a start.
- down_i  input  1  decrement enable, honoured only in COUNT state.
- abort_i  input  1  cancel a running count.
- count_o  output  WIDTH_P  current count, registered.
- busy_o  output  1  high in COUNT state.
- done_o  output  1  one-cycle pulse: timer reached zero.

## Operation
- States: IDLE, COUNT, DONE. A start is accepted when `start_v_i & start_ready_o` at a clock edge.
- Outputs decode from state:
  - `start_ready_o` = IDLE or DONE.
  - `busy_o` = COUNT.
  - `done_o` = DONE.
- Reset, which overrides all other inputs: state IDLE, `count_o`=RESET_VAL, `busy_o`=0, `done_o`=0, `start_ready_o`=1.
- IDLE:
  - `count_o` holds its value.
  - On accept: `count_r`<=`start_val_i`. Next state is COUNT if `start_val_i`≠0, else DONE.
- COUNT:
  - `abort_i`=1: state goes to IDLE and `count_r`<=0. No done pulse. Abort has priority over `down_i`.
  - `down_i`=1 and `count_r`==1: `count_r`<=0 and state goes to DONE.
  - `down_i`=1 and `count_r`>1: `count_r`<=`count_r`-1.
  - `down_i`=0: hold.
  - Starts are not accepted (`start_ready_o`=0), and `start_v_i` is ignored.
- DONE:
  - Lasts exactly one cycle.
  - On accept: `count_r`<=`start_val_i` and state goes to COUNT, or to DONE if the value is 0. This gives back-to-back re-arm with no idle bubble.
  - Otherwise the next state is IDLE and `count_r` stays 0.
- `abort_i` is ignored in IDLE and DONE.
- No wrap-around: the counter never decrements below 0, and `count_r`==0 is never reachable while in COUNT.
- Arithmetic is unsigned at WIDTH_P bits. The comparison to 1 uses the full width.

## Timing
- Latency from a start accepted at edge k with value N≥1 and `down_i` held high:
  - `count_o`=N during cycle k+1.
  - `count_o`=N-i after edge k+i.
  - `count_o`=0 and `done_o`=1 after edge k+N.
  - `done_o` is low again after edge k+N+1, unless re-armed with 0.
- N=0: `done_o`=1 in cycle k+1.
- Each low cycle of `down_i` during COUNT extends the total by one cycle.
- Back-to-back re-arm in DONE: the new value appears on `count_o` the next cycle, and `busy_o` stays contiguous except for the single DONE cycle.
- Reset asserted mid-count: the next cycle shows state IDLE, `count_o`=RESET_VAL and `done_o`=0. A count in flight produces no done pulse.
- All outputs are registered or decoded from registered state, so there are no combinational paths from inputs to outputs.

## Test plan
- Reset with WIDTH_P=4, RESET_VAL=5: after reset, `count_o`=5, `start_ready_o`=1, `busy_o`=0, `done_o`=0.
- Start with value 3, `down_i`=1 throughout:
  - `count_o` sequence is 3,2,1,0.
  - `done_o` is high only in the cycle where `count_o`=0, three cycles after `count_o` first shows 3.
  - The following cycle is IDLE.
- Start with value 4 and `down_i` pattern 1,0,0,1,1,1: `count_o` sequence is 4,3,3,3,2,1,0, with the done pulse in the final cycle.
- Start with 0: `done_o`=1 in the cycle after acceptance, `busy_o` never asserts, and the next state is IDLE.
- Back-to-back: in the DONE cycle present `start_v_i`=1 with value 2.
  - `count_o` goes 2,1,0, and a second done pulse follows.
  - `start_v_i` asserted during COUNT is not accepted.
- Abort and reset mid-count: start with 15 and abort at count 9.
  - Result: IDLE, `count_o`=0, no `done_o`.
  - Repeat using `reset_i` instead of abort: `count_o`=RESET_VAL and no `done_o`.
